// File: rtl/byte_serializer_pkg.sv
// Shared encodings for the byte serializer: width codes, FSM states and
// a byte-count helper.
package byte_serializer_pkg;

  typedef enum logic [1:0] {
    W_FULL = 2'b00,
    W_16   = 2'b01,
    W_8    = 2'b10,
    W_RSVD = 2'b11
  } width_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Number of bytes a word of the given width code produces; zero for reserved.
  function automatic int unsigned byte_count(width_e w, int unsigned full_bytes);
    unique case (w)
      W_FULL:  return full_bytes;
      W_16:    return 2;
      W_8:     return 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// Word-in / byte-out handshake bundle of the byte serializer.
interface byte_serializer_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic [1:0]        width_sel;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic              out_last;
  logic              err_width;

  modport master (
    output width_sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, err_width
  );

  modport slave (
    input  width_sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, err_width
  );

endinterface

// File: rtl/byte_serializer_ser_byte_ctr.sv
// Byte selection and remaining-byte down-counter: loads a word left-aligned so
// the first byte of the selected field is always at the top, then shifts.
module ser_byte_ctr
  import byte_serializer_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned Bytes = DATA_W / 8,
  localparam int unsigned CntW  = $clog2(Bytes) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  width_e            width_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              advance_i,
  input  logic              done_i,
  output logic [7:0]        byte_o,
  output logic              last_o
);

  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] sh_q;
  logic [7:0]        byte_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   load_cnt;
  logic              last_q;

  always_comb begin
    aligned = data_i;
    unique case (width_i)
      W_16:    aligned = DATA_W'(data_i[15:0]) << (DATA_W - 16);
      W_8:     aligned = DATA_W'(data_i[7:0]) << (DATA_W - 8);
      default: aligned = data_i;
    endcase
    load_cnt = CntW'(byte_count(width_i, Bytes));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q   <= '0;
      byte_q <= 8'h00;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else if (load_i) begin
      byte_q <= aligned[DATA_W-1 -: 8];
      sh_q   <= aligned << 8;
      cnt_q  <= load_cnt;
      last_q <= (load_cnt == CntW'(1));
    end else if (advance_i) begin
      byte_q <= sh_q[DATA_W-1 -: 8];
      sh_q   <= sh_q << 8;
      cnt_q  <= (cnt_q != '0) ? cnt_q - CntW'(1) : '0;
      last_q <= (cnt_q == CntW'(2));
    end else if (done_i) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end
  end

  assign byte_o = byte_q;
  assign last_o = last_q;

endmodule

// File: rtl/byte_serializer.sv
// Parallel word to MSB-first byte stream serializer with selectable field width
// and zero-bubble back-to-back word acceptance.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input logic               clk,
  input logic               reset_L,
  byte_serializer_if.slave  bus
);

  if ((DATA_W % 8) != 0 || DATA_W < 16) begin : g_bad_width
    $error("DATA_W must be a multiple of 8 and at least 16");
  end

  state_e state_q;
  logic   valid_q;
  logic   err_q;
  logic   rdy_en_q;
  logic   last;
  logic   take;
  logic   take_last;
  logic   accept;
  logic   rsvd;
  logic   load;
  width_e width;

  assign width     = width_e'(bus.width_sel);
  assign take      = valid_q & bus.out_ready;
  assign take_last = take & last;
  // rdy_en_q keeps in_ready low until the first edge after reset release.
  assign bus.in_ready = rdy_en_q & ((state_q == IDLE) | take_last);
  assign accept    = bus.in_valid & bus.in_ready;
  assign rsvd      = (width == W_RSVD);
  assign load      = accept & ~rsvd;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      err_q    <= accept & rsvd;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= SEND;
            valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (take_last) begin
            if (load) begin
              state_q <= SEND;
              valid_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  ser_byte_ctr #(
    .DATA_W (DATA_W)
  ) u_ser_byte_ctr (
    .clk_i     (clk),
    .rst_ni    (reset_L),
    .load_i    (load),
    .width_i   (width),
    .data_i    (bus.in_data),
    .advance_i (take & ~last),
    .done_i    (take_last),
    .byte_o    (bus.out_data),
    .last_o    (last)
  );

  assign bus.out_valid = valid_q;
  assign bus.out_last  = last & valid_q;
  assign bus.err_width = err_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based model of the expected byte stream.
module tb_byte_serializer;

  localparam int unsigned DATA_W = 32;

  typedef struct {
    logic [7:0] b;
    logic       l;
  } exp_byte_t;

  logic clk;
  logic reset_L;

  byte_serializer_if #(.DATA_W(DATA_W)) bus ();

  byte_serializer #(
    .DATA_W (DATA_W)
  ) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        checks;
  int        errors;
  exp_byte_t exp_q[$];
  logic      rdy_seen;
  logic      exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [1:0] ws);
    case (ws)
      2'b00:   return DATA_W / 8;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 0;
    endcase
  endfunction

  // One clock: drive at the falling edge, check settled outputs, advance model.
  task automatic cycle(input logic v, input logic [1:0] ws, input logic [31:0] d,
                       input logic ordy);
    logic      exp_rdy;
    logic      accept;
    int        n;
    exp_byte_t e;
    bus.in_valid  = v;
    bus.width_sel = ws;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    exp_rdy = rdy_seen && (exp_q.size() == 0 || (ordy && exp_q[0].l));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_data", 32'(bus.out_data), 32'(exp_q[0].b));
      chk("out_last", 32'(bus.out_last), 32'(exp_q[0].l));
    end
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("err_width", 32'(bus.err_width), 32'(exp_err));
    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    accept  = v && exp_rdy;
    exp_err = accept && (ws == 2'b11);
    if (accept) begin
      n = int'(nbytes(ws));
      for (int i = n - 1; i >= 0; i--) begin
        e.b = d[8*i +: 8];
        e.l = (i == 0);
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    rdy_seen = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 32'h0, ordy);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rdy_seen = 1'b0;
    exp_err  = 1'b0;
    reset_L  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.width_sel = 2'b00;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'h00);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_err_width", 32'(bus.err_width), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset_L = 1'b1;

    // Full-width word streamed with sink always ready.
    cycle(1'b1, 2'b00, 32'hA1B2C3D4, 1'b1);
    idle_cycles(5, 1'b1);
    // 16-bit and 8-bit fields of the same data.
    cycle(1'b1, 2'b01, 32'h1234ABCD, 1'b1);
    idle_cycles(3, 1'b1);
    cycle(1'b1, 2'b10, 32'h1234ABCD, 1'b1);
    idle_cycles(2, 1'b1);
    // Back-pressure on the second byte; width_sel changes in flight are ignored.
    cycle(1'b1, 2'b00, 32'hA1B2C3D4, 1'b1);
    cycle(1'b0, 2'b10, 32'h0, 1'b1);
    cycle(1'b1, 2'b01, 32'h55667788, 1'b0);
    cycle(1'b1, 2'b01, 32'h55667788, 1'b0);
    cycle(1'b1, 2'b01, 32'h55667788, 1'b0);
    idle_cycles(4, 1'b1);
    // Back-to-back words with no bubble.
    cycle(1'b1, 2'b00, 32'h01020304, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'b00, 32'h05060708, 1'b1);
    idle_cycles(5, 1'b1);
    // Reserved width code.
    cycle(1'b1, 2'b11, 32'hFFFFFFFF, 1'b1);
    idle_cycles(3, 1'b1);
    // Reset in the middle of a word.
    cycle(1'b1, 2'b00, 32'hA1B2C3D4, 1'b1);
    cycle(1'b0, 2'b00, 32'h0, 1'b1);
    cycle(1'b0, 2'b00, 32'h0, 1'b1);
    reset_L = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_out_data", 32'(bus.out_data), 32'h00);
    exp_q.delete();
    exp_err  = 1'b0;
    rdy_seen = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    cycle(1'b1, 2'b00, 32'h11223344, 1'b1);
    cycle(1'b1, 2'b00, 32'h11223344, 1'b1);
    idle_cycles(5, 1'b1);

    // Random traffic with random back-pressure and width codes.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
            ($urandom_range(0, 3) != 0));
    end
    idle_cycles(6, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter DATA_W, default 32, input word width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter BYTES, derived as DATA_W/8, is the maximum number of bytes emitted per word.
REQ-003 Port clk, input, 1 bit, sole clock; all logic on its rising edge.
REQ-004 Port reset_L, input, 1 bit, asynchronous, active-low reset.
REQ-005 Port width_sel, input, 2 bits, PCLK width code: 00 = full DATA_W, 01 = 16-bit, 10 = 8-bit, 11 = reserved.
REQ-006 Port in_valid, input, 1 bit, in_data and width_sel are valid.
REQ-007 Port in_ready, output, 1 bit, the block accepts a word this cycle.
REQ-008 Port in_data, input, DATA_W bits, parallel word.
REQ-009 Port out_valid, output, 1 bit, out_data holds a valid byte.
REQ-010 Port out_ready, input, 1 bit, the sink takes the byte this cycle.
REQ-011 Port out_data, output, 8 bits, serialized byte.
REQ-012 Port out_last, output, 1 bit, the current byte is the final byte of its word.
REQ-013 Port err_width, output, 1 bit, one-cycle pulse when a word with a reserved width code is accepted.

Function
REQ-014 A word SHALL be accepted when in_valid and in_ready are both high.
REQ-015 width_sel SHALL be sampled only at acceptance; later changes SHALL NOT affect the word in flight.
REQ-016 Byte count SHALL be BYTES for code 00, 2 for code 01 and 1 for code 10.
REQ-017 Byte order SHALL be MSB-first within the selected field:
- code 00: bits [DATA_W-1:DATA_W-8] first, down to [7:0];
- code 01: bits [15:8], then [7:0];
- code 10: bits [7:0] only.
REQ-018 The FSM SHALL have two states:
- IDLE -> SEND on acceptance of a valid-coded word;
- SEND -> IDLE when the last byte is taken and no new word is accepted.
REQ-019 The first byte SHALL appear on out_valid/out_data exactly 1 cycle after acceptance.
REQ-020 In SEND, out_data SHALL advance to the next byte only on a cycle where out_valid and out_ready are both high.
REQ-021 While out_ready is low, out_data, out_valid and out_last SHALL hold steady.
REQ-022 in_ready SHALL be high when the block is in IDLE, or when the last byte is being taken this cycle (out_valid, out_ready and out_last all high).
REQ-023 A word accepted on a last-byte-taken cycle SHALL present its first byte on the next cycle, so back-to-back words produce no bubble.
REQ-024 out_last SHALL be high only on the final byte of each word.
REQ-025 A word with code 11 SHALL be accepted and discarded; err_width SHALL pulse high for 1 cycle; no bytes are emitted.
REQ-026 Remaining bytes SHALL be tracked by a down-counter of width clog2(BYTES)+1 that never wraps below zero.

Reset
REQ-027 On reset_L low, all of the following SHALL be cleared asynchronously: state to IDLE; out_valid, out_last, err_width and the counter to 0; out_data to 8'h00.
REQ-028 in_ready SHALL be 0 while reset_L is low and SHALL rise on the first clk edge after deassertion.
REQ-029 A reset in the middle of a word SHALL drop that word's remaining bytes; nothing SHALL be replayed after reset.

Structure
REQ-030 A shared package SHALL hold the width_sel encodings (W_FULL, W_16, W_8, W_RSVD) and the state encodings (IDLE, SEND).
REQ-031 Byte selection and the down-counter SHALL live in one sub-module, ser_byte_ctr, instantiated once.

Verification
REQ-032 Scenario: DATA_W=32, code 00, in_data=32'hA1B2C3D4, out_ready held 1 -> bytes A1, B2, C3, D4 on 4 consecutive cycles, out_last on D4 only.
REQ-033 Scenario: code 01, in_data=32'h1234ABCD -> bytes AB, CD; code 10, same data -> byte CD alone with out_last=1.
REQ-034 Scenario: out_ready low for 3 cycles on byte B2 -> B2 held for 3 cycles, in_ready stays 0, no bytes lost.
REQ-035 Scenario: two words 32'h01020304 and 32'h05060708 offered back to back -> 8 consecutive bytes 01..08, second word accepted on the cycle 04 is taken.
REQ-036 Scenario: code 11 with in_data=32'hFFFFFFFF -> err_width high for 1 cycle, out_valid stays 0.
REQ-037 Scenario: reset_L pulsed low after byte B2 of 32'hA1B2C3D4 -> out_valid=0 immediately, next word begins with its own first byte.
